// File: rtl/fg_pkg.sv
// Shared definitions for the trapezoid generator: FSM encoding and the
// signed saturation limits of the waveform output.
package fg_pkg;

    localparam int FG_STATE_W = 3;

    typedef enum logic [FG_STATE_W-1:0] {
        ST_IDLE = 3'd0,
        ST_RISE = 3'd1,
        ST_ON   = 3'd2,
        ST_FALL = 3'd3,
        ST_OFF  = 3'd4
    } fg_state_e;

    // Largest and smallest value of a signed (w+1)-bit waveform sample.
    function automatic longint fg_out_max(input int unsigned w);
        return (longint'(1) << w) - 1;
    endfunction

    function automatic longint fg_out_min(input int unsigned w);
        return -(longint'(1) << w);
    endfunction

endpackage

// File: rtl/fg_sat_step.sv
// Signed add of two operands, clamped to [lo_i, hi_i]. The sum is formed one
// bit wider than the operands so it can never wrap before clamping.
module fg_sat_step #(
    parameter int W = 18
) (
    input  logic signed [W-1:0] a_i,
    input  logic signed [W-1:0] b_i,
    input  logic signed [W-1:0] lo_i,
    input  logic signed [W-1:0] hi_i,
    output logic signed [W-1:0] y_o
);

    logic signed [W:0] sum_x;
    logic signed [W:0] lo_x;
    logic signed [W:0] hi_x;

    assign sum_x = (W+1)'(a_i) + (W+1)'(b_i);
    assign lo_x  = (W+1)'(lo_i);
    assign hi_x  = (W+1)'(hi_i);

    always_comb begin
        if (sum_x > hi_x) begin
            y_o = hi_i;
        end else if (sum_x < lo_x) begin
            y_o = lo_i;
        end else begin
            y_o = sum_x[W-1:0];
        end
    end

endmodule

// File: rtl/fg_trapezoid_gen.sv
// Trapezoid waveform generator with shadowed configuration applied at period wrap.
// Define FG_TRAP_OFFSET_EN to add the signed offset input and saturating output adder.
module fg_trapezoid_gen
    import fg_pkg::*;
#(
    parameter int COUNTER_BITWIDTH  = 32,
    parameter int WAVEFORM_BITWIDTH = 16
) (
    input  logic                                 clk_i,
    input  logic                                 rst_i,
    input  logic                                 clk_en_i,
    input  logic                                 en_i,
    input  logic                                 cfg_valid_i,
    output logic                                 cfg_ready_o,
    input  logic [COUNTER_BITWIDTH-1:0]          period_i,
    input  logic [COUNTER_BITWIDTH-1:0]          on_time_i,
    input  logic [WAVEFORM_BITWIDTH-1:0]         k_rise_i,
    input  logic [WAVEFORM_BITWIDTH-1:0]         k_fall_i,
    input  logic [WAVEFORM_BITWIDTH-1:0]         amplitude_i,
    input  logic                                 oneshot_i,
    input  logic                                 invert_i,
`ifdef FG_TRAP_OFFSET_EN
    input  logic signed [WAVEFORM_BITWIDTH:0]    offset_i,
`endif
    output logic signed [WAVEFORM_BITWIDTH:0]    out_o,
    output logic [FG_STATE_W-1:0]                state_o,
    output logic                                 period_start_o,
    output logic                                 busy_o
);

    localparam int C = COUNTER_BITWIDTH;
    localparam int W = WAVEFORM_BITWIDTH;

    logic [C-1:0]      sh_period_q, sh_on_q, act_period_q, act_on_q, cnt_q;
    logic [W-1:0]      sh_krise_q, sh_kfall_q, sh_amp_q;
    logic [W-1:0]      act_krise_q, act_kfall_q, act_amp_q, val_q;
    logic              sh_oneshot_q, sh_invert_q, act_oneshot_q, act_invert_q;
    logic              pending_q, applied_q, pstart_q;
    logic signed [W:0] out_q;
    fg_state_e         state_q;

    logic              accept, apply, wrap, fall_evt, at_amp, at_zero;
    logic [C-1:0]      on_clamped;
    logic signed [W:0] step_a, step_b, step_hi, step_y;
    logic signed [W:0] val_signed, out_d;

    assign accept     = cfg_valid_i && !pending_q;
    assign wrap       = (state_q != ST_IDLE) && (cnt_q == act_period_q - C'(1));
    assign fall_evt   = (cnt_q == act_on_q - C'(1));
    assign apply      = pending_q && ((state_q == ST_IDLE) || (clk_en_i && wrap));
    assign on_clamped = (sh_on_q >= sh_period_q) ? sh_period_q - C'(1) : sh_on_q;

    // One stepper serves both ramps: +k_rise in RISE, -k_fall in FALL, kept in [0, amplitude].
    assign step_a  = $signed({1'b0, val_q});
    assign step_b  = (state_q == ST_FALL) ? -$signed({1'b0, act_kfall_q})
                                          :  $signed({1'b0, act_krise_q});
    assign step_hi = $signed({1'b0, act_amp_q});
    assign at_amp  = (step_y == step_hi);
    assign at_zero = (step_y == '0);

    fg_sat_step #(.W(W+1)) u_val_step (
        .a_i  (step_a),
        .b_i  (step_b),
        .lo_i ('0),
        .hi_i (step_hi),
        .y_o  (step_y)
    );

    assign val_signed = act_invert_q ? -$signed({1'b0, val_q}) : $signed({1'b0, val_q});

`ifdef FG_TRAP_OFFSET_EN
    localparam logic signed [W:0] OUT_MAX = (W+1)'(fg_out_max(W));
    localparam logic signed [W:0] OUT_MIN = (W+1)'(fg_out_min(W));

    logic signed [W:0] sh_offset_q, act_offset_q;

    fg_sat_step #(.W(W+1)) u_out_add (
        .a_i  (val_signed),
        .b_i  (act_offset_q),
        .lo_i (OUT_MIN),
        .hi_i (OUT_MAX),
        .y_o  (out_d)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_offset_q  <= '0;
            act_offset_q <= '0;
        end else begin
            if (accept) sh_offset_q  <= offset_i;
            if (apply)  act_offset_q <= sh_offset_q;
        end
    end
`else
    assign out_d = val_signed;
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sh_period_q   <= '0;
            sh_on_q       <= '0;
            sh_krise_q    <= '0;
            sh_kfall_q    <= '0;
            sh_amp_q      <= '0;
            sh_oneshot_q  <= 1'b0;
            sh_invert_q   <= 1'b0;
            act_period_q  <= '0;
            act_on_q      <= '0;
            act_krise_q   <= '0;
            act_kfall_q   <= '0;
            act_amp_q     <= '0;
            act_oneshot_q <= 1'b0;
            act_invert_q  <= 1'b0;
            pending_q     <= 1'b0;
            applied_q     <= 1'b0;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            val_q         <= '0;
            out_q         <= '0;
            pstart_q      <= 1'b0;
        end else begin
            out_q    <= out_d;
            pstart_q <= 1'b0;
            if (accept) begin
                sh_period_q  <= period_i;
                sh_on_q      <= on_time_i;
                sh_krise_q   <= k_rise_i;
                sh_kfall_q   <= k_fall_i;
                sh_amp_q     <= amplitude_i;
                sh_oneshot_q <= oneshot_i;
                sh_invert_q  <= invert_i;
                pending_q    <= 1'b1;
            end
            if (clk_en_i) begin
                if (!en_i || act_period_q == '0) begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    val_q   <= '0;
                end else begin
                    cnt_q <= (state_q == ST_IDLE || wrap) ? '0 : cnt_q + C'(1);
                    case (state_q)
                        ST_IDLE: begin
                            val_q <= '0;
                            if (applied_q) begin
                                state_q  <= ST_RISE;
                                pstart_q <= 1'b1;
                            end
                        end
                        ST_RISE: begin
                            if (wrap) begin
                                pstart_q <= 1'b1;
                            end else begin
                                val_q <= step_y[W-1:0];
                                if (fall_evt)    state_q <= ST_FALL;
                                else if (at_amp) state_q <= ST_ON;
                            end
                        end
                        ST_ON: begin
                            if (wrap) begin
                                state_q  <= ST_RISE;
                                pstart_q <= 1'b1;
                            end else if (fall_evt) begin
                                state_q <= ST_FALL;
                            end
                        end
                        ST_FALL: begin
                            if (wrap) begin
                                state_q  <= ST_RISE;
                                pstart_q <= 1'b1;
                            end else begin
                                val_q <= step_y[W-1:0];
                                if (at_zero) state_q <= ST_OFF;
                            end
                        end
                        ST_OFF: begin
                            val_q <= '0;
                            if (wrap) begin
                                // A finished oneshot consumes its configuration so it does not relaunch.
                                if (act_oneshot_q) begin
                                    state_q   <= ST_IDLE;
                                    applied_q <= 1'b0;
                                end else begin
                                    state_q  <= ST_RISE;
                                    pstart_q <= 1'b1;
                                end
                            end
                        end
                        default: begin
                            state_q <= ST_IDLE;
                            val_q   <= '0;
                        end
                    endcase
                end
            end
            if (apply) begin
                act_period_q  <= sh_period_q;
                act_on_q      <= on_clamped;
                act_krise_q   <= sh_krise_q;
                act_kfall_q   <= sh_kfall_q;
                act_amp_q     <= sh_amp_q;
                act_oneshot_q <= sh_oneshot_q;
                act_invert_q  <= sh_invert_q;
                pending_q     <= 1'b0;
                applied_q     <= 1'b1;
            end
        end
    end

    assign cfg_ready_o    = !pending_q;
    assign out_o          = out_q;
    assign state_o        = state_q;
    assign period_start_o = pstart_q;
    assign busy_o         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fg_trapezoid_gen.sv
// Directed self-checking bench for fg_trapezoid_gen (W=8, C=8); the offset
// scenario is exercised when FG_TRAP_OFFSET_EN is defined.
module tb_fg_trapezoid_gen;

    localparam int C = 8;
    localparam int W = 8;

    logic              clk, rst, clk_en, en, cfg_valid, cfg_ready;
    logic [C-1:0]      period, on_time;
    logic [W-1:0]      k_rise, k_fall, amp;
    logic              oneshot, invert;
`ifdef FG_TRAP_OFFSET_EN
    logic signed [W:0] offset;
`endif
    logic signed [W:0] out;
    logic [2:0]        state;
    logic              pstart, busy;

    int tests_run    = 0;
    int tests_failed = 0;

    fg_trapezoid_gen #(.COUNTER_BITWIDTH(C), .WAVEFORM_BITWIDTH(W)) dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .clk_en_i       (clk_en),
        .en_i           (en),
        .cfg_valid_i    (cfg_valid),
        .cfg_ready_o    (cfg_ready),
        .period_i       (period),
        .on_time_i      (on_time),
        .k_rise_i       (k_rise),
        .k_fall_i       (k_fall),
        .amplitude_i    (amp),
        .oneshot_i      (oneshot),
        .invert_i       (invert),
`ifdef FG_TRAP_OFFSET_EN
        .offset_i       (offset),
`endif
        .out_o          (out),
        .state_o        (state),
        .period_start_o (pstart),
        .busy_o         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; cfg_valid = 1'b0; en = 1'b0; clk_en = 1'b1;
        period = '0; on_time = '0; k_rise = '0; k_fall = '0; amp = '0;
        oneshot = 1'b0; invert = 1'b0;
`ifdef FG_TRAP_OFFSET_EN
        offset = '0;
`endif
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic send_cfg(input int p, input int on, input int kr, input int kf,
                            input int a, input bit os, input bit inv, input int offs);
        int waited = 0;
        period = C'(p); on_time = C'(on); k_rise = W'(kr); k_fall = W'(kf); amp = W'(a);
        oneshot = os; invert = inv;
`ifdef FG_TRAP_OFFSET_EN
        offset = (W+1)'(offs);
`else
        if (offs != 0) $display("[TB] offset %0d ignored: feature not built", offs);
`endif
        while (!cfg_ready && waited < 50) begin
            tick();
            waited++;
        end
        if (!cfg_ready) begin
            tests_run++; tests_failed++;
            $display("FAIL cfg_handshake cfg_ready=%0b required=1", cfg_ready);
        end
        cfg_valid = 1'b1;
        tick();
        cfg_valid = 1'b0;
    endtask

    task automatic wait_start(input string name);
        int n = 0;
        do begin
            tick();
            n++;
        end while (!pstart && n < 10);
        tests_run++;
        if (!pstart) begin
            tests_failed++;
            $display("FAIL %s_start period_start=%0b required=1 after %0d cycles", name, pstart, n);
        end
    endtask

    task automatic test_reset();
        do_reset();
        tests_run += 5;
        if (state !== 3'd0)  begin tests_failed++; $display("FAIL reset_state got=%0d exp=0", state); end
        if (out !== '0)      begin tests_failed++; $display("FAIL reset_out got=%0d exp=0", out); end
        if (busy !== 1'b0)   begin tests_failed++; $display("FAIL reset_busy got=%0b exp=0", busy); end
        if (cfg_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_ready got=%0b exp=1", cfg_ready); end
        if (pstart !== 1'b0) begin tests_failed++; $display("FAIL reset_pstart got=%0b exp=0", pstart); end
        $display("[TB] test_reset done");
    endtask

    task automatic test_basic();
        int exp_val[20] = '{0, 50, 100, 150, 200, 200, 200, 200, 200, 200,
                            200, 175, 150, 125, 100, 75, 50, 25, 0, 0};
        int exp_st[20]  = '{1, 1, 1, 1, 2, 2, 2, 2, 2, 2,
                            3, 3, 3, 3, 3, 3, 3, 3, 4, 4};
        int prev = 0;
        do_reset();
        en = 1'b1;
        send_cfg(20, 10, 50, 25, 200, 1'b0, 1'b0, 0);
        wait_start("basic");
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            tests_run++;
            if (state !== 3'(exp_st[i]) || out !== (W+1)'(prev)) begin
                tests_failed++;
                $display("FAIL basic_cycle%0d state=%0d exp=%0d out=%0d exp=%0d",
                         i, state, exp_st[i], out, prev);
            end
            prev = exp_val[i];
        end
        tick();
        tests_run++;
        if (pstart !== 1'b1 || state !== 3'd1 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_wrap pstart=%0b state=%0d busy=%0b exp 1/1/1", pstart, state, busy);
        end
        $display("[TB] test_basic done");
    endtask

    task automatic test_rise_clamp();
        int exp_out[4] = '{30, 60, 90, 100};
        do_reset();
        en = 1'b1;
        send_cfg(20, 15, 30, 50, 100, 1'b0, 1'b0, 0);
        wait_start("rise_clamp");
        for (int i = 1; i <= 5; i++) begin
            tick();
            if (i >= 2) begin
                tests_run++;
                if (out !== (W+1)'(exp_out[i-2])) begin
                    tests_failed++;
                    $display("FAIL rise_clamp_out cycle%0d got=%0d exp=%0d", i, out, exp_out[i-2]);
                end
            end
            if (i == 3 || i == 4) begin
                tests_run++;
                if (state !== ((i == 3) ? 3'd1 : 3'd2)) begin
                    tests_failed++;
                    $display("FAIL rise_clamp_state cycle%0d got=%0d exp=%0d", i, state, (i == 3) ? 1 : 2);
                end
            end
        end
        $display("[TB] test_rise_clamp done");
    endtask

    task automatic test_early_fall();
        bit saw_on = 1'b0;
        do_reset();
        en = 1'b1;
        send_cfg(20, 2, 10, 5, 200, 1'b0, 1'b0, 0);
        wait_start("early_fall");
        for (int i = 0; i < 20; i++) begin
            if (i > 0) tick();
            if (state == 3'd2) saw_on = 1'b1;
            if (i == 1 || i == 2 || i == 6) begin
                tests_run++;
                if (state !== ((i == 1) ? 3'd1 : (i == 2) ? 3'd3 : 3'd4)) begin
                    tests_failed++;
                    $display("FAIL early_fall_state cycle%0d got=%0d", i, state);
                end
            end
            if (i == 3) begin
                tests_run++;
                if (out !== 9'sd20) begin
                    tests_failed++;
                    $display("FAIL early_fall_val got=%0d exp=20", out);
                end
            end
        end
        tests_run++;
        if (saw_on) begin
            tests_failed++;
            $display("FAIL early_fall_no_on saw_on=%0b exp=0", saw_on);
        end
        $display("[TB] test_early_fall done");
    endtask

    task automatic test_on_clamp_wrap();
        int exp_st[4] = '{2, 3, 1, 2};
        do_reset();
        en = 1'b1;
        send_cfg(10, 30, 100, 10, 100, 1'b0, 1'b0, 0);
        wait_start("on_clamp");
        for (int i = 1; i <= 11; i++) begin
            tick();
            if (i >= 8) begin
                tests_run++;
                if (state !== 3'(exp_st[i-8])) begin
                    tests_failed++;
                    $display("FAIL on_clamp_state cycle%0d got=%0d exp=%0d", i, state, exp_st[i-8]);
                end
            end
            if (i == 10) begin
                tests_run++;
                if (pstart !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL on_clamp_pstart got=%0b exp=1", pstart);
                end
            end
        end
        tests_run++;
        if (out !== 9'sd100) begin
            tests_failed++;
            $display("FAIL wrap_keeps_val got=%0d exp=100", out);
        end
        $display("[TB] test_on_clamp_wrap done");
    endtask

    task automatic test_reconfig();
        do_reset();
        en = 1'b1;
        send_cfg(20, 10, 50, 25, 200, 1'b0, 1'b0, 0);
        wait_start("reconfig");
        for (int i = 1; i <= 19; i++) begin
            tick();
            if (i == 5) begin
                period = 8'd10; on_time = 8'd5; k_rise = 8'd100; k_fall = 8'd100; amp = 8'd100;
                cfg_valid = 1'b1;
            end
            if (i == 6) begin
                cfg_valid = 1'b0;
                tests_run++;
                if (cfg_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL reconfig_ready_low got=%0b exp=0", cfg_ready);
                end
            end
            if (i == 8) begin
                amp = 8'd60; k_rise = 8'd20;
                cfg_valid = 1'b1;
            end
            if (i == 19) begin
                tests_run++;
                if (cfg_ready !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL reconfig_stall got=%0b exp=0", cfg_ready);
                end
                cfg_valid = 1'b0;
            end
        end
        tick();
        tests_run++;
        if (pstart !== 1'b1 || cfg_ready !== 1'b1 || state !== 3'd1) begin
            tests_failed++;
            $display("FAIL reconfig_apply pstart=%0b ready=%0b state=%0d exp 1/1/1", pstart, cfg_ready, state);
        end
        tick();
        tests_run++;
        if (state !== 3'd2) begin
            tests_failed++;
            $display("FAIL reconfig_new_rise state=%0d exp=2", state);
        end
        tick();
        tests_run++;
        if (out !== 9'sd100) begin
            tests_failed++;
            $display("FAIL reconfig_new_amp out=%0d exp=100", out);
        end
        for (int j = 3; j <= 10; j++) tick();
        tests_run++;
        if (pstart !== 1'b1) begin
            tests_failed++;
            $display("FAIL reconfig_new_period pstart=%0b exp=1", pstart);
        end
        $display("[TB] test_reconfig done");
    endtask

    task automatic test_invert_offset();
        do_reset();
        en = 1'b1;
`ifdef FG_TRAP_OFFSET_EN
        send_cfg(10, 5, 200, 200, 200, 1'b0, 1'b1, -100);
        wait_start("offset_neg");
        tick(); tick();
        tests_run++;
        if (out !== -9'sd256) begin
            tests_failed++;
            $display("FAIL offset_sat_neg out=%0d exp=-256", out);
        end
        do_reset();
        en = 1'b1;
        send_cfg(10, 5, 200, 200, 200, 1'b0, 1'b0, -100);
        wait_start("offset_pos");
        tick(); tick();
        tests_run++;
        if (out !== 9'sd100) begin
            tests_failed++;
            $display("FAIL offset_peak out=%0d exp=100", out);
        end
`else
        send_cfg(10, 5, 50, 50, 100, 1'b0, 1'b1, 0);
        wait_start("invert");
        tick(); tick();
        tests_run++;
        if (out !== -9'sd50) begin
            tests_failed++;
            $display("FAIL invert_step out=%0d exp=-50", out);
        end
        tick();
        tests_run++;
        if (out !== -9'sd100) begin
            tests_failed++;
            $display("FAIL invert_peak out=%0d exp=-100", out);
        end
`endif
        $display("[TB] test_invert_offset done");
    endtask

    task automatic test_clk_en();
        do_reset();
        en = 1'b1;
        clk_en = 1'b0;
        send_cfg(10, 5, 100, 100, 100, 1'b0, 1'b0, 0);
        tests_run++;
        if (cfg_ready !== 1'b0) begin
            tests_failed++;
            $display("FAIL clken_accept ready=%0b exp=0", cfg_ready);
        end
        tick();
        tests_run++;
        if (cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL clken_idle_apply ready=%0b exp=1", cfg_ready);
        end
        tick(); tick();
        tests_run++;
        if (state !== 3'd0) begin
            tests_failed++;
            $display("FAIL clken_hold_idle state=%0d exp=0", state);
        end
        clk_en = 1'b1;
        tick();
        tests_run++;
        if (state !== 3'd1 || pstart !== 1'b1) begin
            tests_failed++;
            $display("FAIL clken_start state=%0d pstart=%0b exp 1/1", state, pstart);
        end
        clk_en = 1'b0;
        tick();
        tests_run++;
        if (state !== 3'd1 || pstart !== 1'b0) begin
            tests_failed++;
            $display("FAIL clken_freeze state=%0d pstart=%0b exp 1/0", state, pstart);
        end
        clk_en = 1'b1;
        tick();
        tests_run++;
        if (state !== 3'd2) begin
            tests_failed++;
            $display("FAIL clken_resume state=%0d exp=2", state);
        end
        $display("[TB] test_clk_en done");
    endtask

    task automatic test_en_low();
        do_reset();
        en = 1'b1;
        send_cfg(20, 10, 50, 25, 200, 1'b0, 1'b0, 0);
        wait_start("en_low");
        for (int i = 1; i <= 5; i++) tick();
        en = 1'b0;
        tick();
        tests_run++;
        if (state !== 3'd0 || busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_low_idle state=%0d busy=%0b exp 0/0", state, busy);
        end
        tick();
        tests_run++;
        if (out !== '0) begin
            tests_failed++;
            $display("FAIL en_low_val out=%0d exp=0", out);
        end
        en = 1'b1;
        tick();
        tests_run++;
        if (state !== 3'd1 || pstart !== 1'b1) begin
            tests_failed++;
            $display("FAIL en_low_restart state=%0d pstart=%0b exp 1/1", state, pstart);
        end
        $display("[TB] test_en_low done");
    endtask

    task automatic test_oneshot();
        do_reset();
        en = 1'b1;
        send_cfg(10, 5, 100, 100, 100, 1'b1, 1'b0, 0);
        wait_start("oneshot");
        for (int i = 1; i <= 9; i++) tick();
        tests_run++;
        if (state !== 3'd4 || busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL oneshot_off state=%0d busy=%0b exp 4/1", state, busy);
        end
        tick();
        tests_run++;
        if (state !== 3'd0 || busy !== 1'b0 || pstart !== 1'b0) begin
            tests_failed++;
            $display("FAIL oneshot_end state=%0d busy=%0b pstart=%0b exp 0/0/0", state, busy, pstart);
        end
        tick(); tick(); tick();
        tests_run++;
        if (state !== 3'd0) begin
            tests_failed++;
            $display("FAIL oneshot_stays_idle state=%0d exp=0", state);
        end
        $display("[TB] test_oneshot done");
    endtask

    task automatic test_reset_mid();
        do_reset();
        en = 1'b1;
        send_cfg(20, 10, 10, 10, 200, 1'b0, 1'b0, 0);
        wait_start("reset_mid");
        tick(); tick(); tick();
        tests_run++;
        if (out !== 9'sd20) begin
            tests_failed++;
            $display("FAIL reset_mid_pre out=%0d exp=20", out);
        end
        rst = 1'b1; clk_en = 1'b0; cfg_valid = 1'b1;
        tick();
        tests_run++;
        if (state !== 3'd0 || busy !== 1'b0 || out !== '0 || cfg_ready !== 1'b1 || pstart !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid state=%0d busy=%0b out=%0d ready=%0b pstart=%0b exp 0/0/0/1/0",
                     state, busy, out, cfg_ready, pstart);
        end
        rst = 1'b0; clk_en = 1'b1; cfg_valid = 1'b0;
        tick(); tick(); tick();
        tests_run++;
        if (state !== 3'd0 || cfg_ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_cleared state=%0d ready=%0b exp 0/1", state, cfg_ready);
        end
        $display("[TB] test_reset_mid done");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rise_clamp();
        test_early_fall();
        test_on_clamp_wrap();
        test_reconfig();
        test_invert_offset();
        test_clk_en();
        test_en_low();
        test_oneshot();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
